prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_unit_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 61 ++++++
 rtl/prefetch_unit.sv | 124 ++++++++++++
 tb/tb_prefetch_unit.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prefetch_unit_pkg.sv
// Shared defaults and state encoding for the instruction prefetch unit.
package prefetch_unit_pkg;

    localparam int          PFU_ADDR_W   = 64;
    localparam int          PFU_INST_W   = 32;
    localparam int          PFU_DEPTH    = 4;
    localparam logic [63:0] PFU_RESET_PC = 64'h0;

    // RUN: responses are kept; DRAIN: responses belong to a flushed stream.
    localparam logic [0:0]  ST_RUN       = 1'b0;
    localparam logic [0:0]  ST_DRAIN     = 1'b1;

endpackage : prefetch_unit_pkg

// File: rtl/fetch_fifo.sv
// Parametrised synchronous FIFO with flush; head is presented combinationally.
module fetch_fifo #(
    parameter int  WIDTH = 32,
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        // NOTE: default first so every path assigns count_d and no latch is inferred.
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is deliberately not reset; count/pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule : fetch_fifo

// File: rtl/prefetch_unit.sv
// Credit-based instruction prefetcher: issues sequential fetches, queues in-order
// responses with their PCs, and discards responses of a stream killed by redirect.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = PFU_ADDR_W,
    parameter int                INST_W   = PFU_INST_W,
    parameter int                DEPTH    = PFU_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PFU_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [INST_W-1:0] mem_rsp_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [INST_W-1:0] out_inst
);

    localparam int             CNT_W   = $clog2(DEPTH + 1);
    localparam int             ENT_W   = ADDR_W + INST_W;
    localparam logic [CNT_W:0] CREDITS = (CNT_W + 1)'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [0:0]        state_q, state_d;

    logic [CNT_W-1:0]  count, pc_count;
    logic [ADDR_W-1:0] pc_head;
    logic [ENT_W-1:0]  q_head, q_push_data;
    logic              credit_ok, req_fire, rsp_keep, pop;
    logic              pc_empty, pc_push, pc_pop;

    // Queued entries plus in-flight requests never exceed the queue depth.
    assign credit_ok     = ({1'b0, count} + {1'b0, outstanding_q}) < CREDITS;
    assign mem_req_valid = !rst && !redirect && credit_ok;
    assign mem_req_addr  = fetch_pc_q;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign rsp_keep = mem_rsp_valid && (state_q == ST_RUN) && !redirect && !rst;

    // A zero-latency response overtakes its own PC push: take the PC straight
    // from the request and skip the side-FIFO for that beat.
    assign pc_empty    = (pc_count == '0);
    assign pc_pop      = rsp_keep && !pc_empty;
    assign pc_push     = req_fire && !(rsp_keep && pc_empty);
    assign q_push_data = {(pc_empty ? fetch_pc_q : pc_head), mem_rsp_data};

    assign out_valid = !rst && (count != '0);
    assign pop       = out_valid && out_ready && !redirect;
    assign out_pc    = q_head[ENT_W-1 -: ADDR_W];
    assign out_inst  = q_head[INST_W-1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = redirect_pc & ~ADDR_W'(3);
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end

        outstanding_d = outstanding_q + CNT_W'(req_fire) - CNT_W'(mem_rsp_valid);

        // A response arriving with the redirect is itself stale and consumed now.
        drop_cnt_d = drop_cnt_q;
        if (redirect) begin
            drop_cnt_d = outstanding_q - CNT_W'(mem_rsp_valid);
        end else if (mem_rsp_valid && (state_q == ST_DRAIN)) begin
            drop_cnt_d = drop_cnt_q - CNT_W'(1);
        end

        state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            state_q       <= ST_RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            state_q       <= state_d;
        end
    end

    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (rsp_keep),
        .data_i  (q_push_data),
        .pop_i   (pop),
        .head_o  (q_head),
        .count_o (count)
    );

    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_pc_q (
        .clk     (clk),
        .rst     (rst),
        .flush_i (redirect),
        .push_i  (pc_push),
        .data_i  (mem_req_addr),
        .pop_i   (pc_pop),
        .head_o  (pc_head),
        .count_o (pc_count)
    );

endmodule : prefetch_unit

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit: latency-programmable in-order memory model,
// negedge monitor, hand-computed expected PC streams.
module tb_prefetch_unit;

    localparam logic [63:0] RPC     = 64'h1000;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
    localparam logic [63:0] NONE    = 64'hDEAD_DEAD_DEAD_DEAD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic        rst, redirect, mem_req_valid, mem_req_ready, mem_rsp_valid;
    logic        out_valid, out_ready;
    logic [63:0] redirect_pc, mem_req_addr, out_pc, rsp_addr;
    logic [31:0] mem_rsp_data, out_inst;

    // wrap-around instance
    logic        rst_w, mem_req_valid_w, mem_req_ready_w, mem_rsp_valid_w, out_valid_w, out_ready_w;
    logic [63:0] mem_req_addr_w, out_pc_w;
    logic [31:0] mem_rsp_data_w, out_inst_w;

    int n_checks = 0;
    int n_errors = 0;
    int lat      = 0;
    int cyc      = 0;

    logic [63:0] req_q[$], out_q[$], inst_q[$], req_w_q[$], out_w_q[$];
    logic [63:0] rcyc_q[$], ocyc_q[$];

    function automatic logic [31:0] inst_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [63:0] q_at(input logic [63:0] q[$], input int i);
        return (i < q.size()) ? q[i] : NONE;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        req_q.delete();
        out_q.delete();
        inst_q.delete();
        rcyc_q.delete();
        ocyc_q.delete();
        req_w_q.delete();
        out_w_q.delete();
    endtask

    task automatic do_reset(input int l);
        rst      = 1'b1;
        redirect = 1'b0;
        lat      = l;
        step();
        step();
        clear_mon();
        rst = 1'b0;
    endtask

    prefetch_unit #(
        .ADDR_W   (64),
        .INST_W   (32),
        .DEPTH    (4),
        .RESET_PC (RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst)
    );

    prefetch_unit #(
        .ADDR_W   (64),
        .INST_W   (32),
        .DEPTH    (4),
        .RESET_PC (WRAP_PC)
    ) dut_w (
        .clk           (clk),
        .rst           (rst_w),
        .redirect      (1'b0),
        .redirect_pc   (64'h0),
        .mem_req_valid (mem_req_valid_w),
        .mem_req_ready (mem_req_ready_w),
        .mem_req_addr  (mem_req_addr_w),
        .mem_rsp_valid (mem_rsp_valid_w),
        .mem_rsp_data  (mem_rsp_data_w),
        .out_valid     (out_valid_w),
        .out_ready     (out_ready_w),
        .out_pc        (out_pc_w),
        .out_inst      (out_inst_w)
    );

    // In-order memory: latency 0 answers combinationally, 1..4 via a shift pipe.
    logic [3:0]  pv;
    logic [63:0] pa [4];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) pv <= '0;
        else     pv <= {pv[2:0], mem_req_valid && mem_req_ready};
        pa[0] <= mem_req_addr;
        for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
    end

    always_comb begin
        if (lat == 0) begin
            mem_rsp_valid = mem_req_valid && mem_req_ready;
            rsp_addr      = mem_req_addr;
        end else begin
            mem_rsp_valid = pv[lat-1];
            rsp_addr      = pa[lat-1];
        end
    end
    assign mem_rsp_data = inst_of(rsp_addr);

    assign mem_req_ready_w = 1'b1;
    assign mem_rsp_valid_w = mem_req_valid_w && mem_req_ready_w;
    assign mem_rsp_data_w  = inst_of(mem_req_addr_w);

    always @(negedge clk) begin
        if (mem_req_valid && mem_req_ready) begin
            req_q.push_back(mem_req_addr);
            rcyc_q.push_back(64'(cyc));
        end
        if (out_valid && out_ready) begin
            out_q.push_back(out_pc);
            inst_q.push_back({32'h0, out_inst});
            ocyc_q.push_back(64'(cyc));
        end
        if (mem_req_valid_w && mem_req_ready_w) req_w_q.push_back(mem_req_addr_w);
        if (out_valid_w && out_ready_w)         out_w_q.push_back(out_pc_w);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic stale;

        rst = 1'b1; rst_w = 1'b1; redirect = 1'b0; redirect_pc = '0;
        mem_req_ready = 1'b1; out_ready = 1'b1; out_ready_w = 1'b1; lat = 0;

        // Reset state, with a redirect held during reset (reset must win).
        step();
        redirect = 1'b1; redirect_pc = 64'h9000;
        step();
        @(negedge clk);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_w_req_valid", mem_req_valid_w, 0);
        step();
        redirect = 1'b0;
        clear_mon();
        rst = 1'b0;

        // Zero-latency streaming.
        @(negedge clk);
        check("a_first_addr", mem_req_addr, RPC);
        check("a_first_out_valid", out_valid, 0);
        repeat (8) step();
        check("a_out0", q_at(out_q, 0), 64'h1000);
        check("a_out1", q_at(out_q, 1), 64'h1004);
        check("a_out2", q_at(out_q, 2), 64'h1008);
        check("a_inst0", q_at(inst_q, 0), {32'h0, inst_of(64'h1000)});
        check("a_inst2", q_at(inst_q, 2), {32'h0, inst_of(64'h1008)});
        check("a_b2b", q_at(ocyc_q, 2) - q_at(ocyc_q, 0), 2);
        check("a_latency", q_at(ocyc_q, 0) - q_at(rcyc_q, 0), 1);

        // Back-pressure: queue fills with exactly DEPTH entries.
        do_reset(1);
        out_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("b_n_req", req_q.size(), 4);
        check("b_req0", q_at(req_q, 0), 64'h1000);
        check("b_req3", q_at(req_q, 3), 64'h100C);
        check("b_req_stall", mem_req_valid, 0);
        check("b_head_pc", out_pc, 64'h1000);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("b_still_full", mem_req_valid, 0);
        step();
        out_ready = 1'b0;
        @(negedge clk);
        check("b_req_resume", mem_req_valid, 1);
        check("b_req_addr", mem_req_addr, 64'h1010);
        check("b_head_after_pop", out_pc, 64'h1004);
        out_ready = 1'b1;

        // Redirect with two outstanding at latency 3.
        do_reset(3);
        step();
        step();
        mem_req_ready = 1'b0;
        redirect = 1'b1; redirect_pc = 64'h2002;
        @(negedge clk);
        check("c_redir_no_req", mem_req_valid, 0);
        step();
        redirect = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        check("c_next_addr", mem_req_addr, 64'h2000);
        repeat (15) step();
        check("c_req2", q_at(req_q, 2), 64'h2000);
        check("c_out0", q_at(out_q, 0), 64'h2000);
        check("c_out1", q_at(out_q, 1), 64'h2004);
        check("c_inst0", q_at(inst_q, 0), {32'h0, inst_of(64'h2000)});

        // Redirect coinciding with the first response (3 outstanding).
        do_reset(3);
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 64'h5000;
        step();
        redirect = 1'b0;
        repeat (16) step();
        check("d_out0", q_at(out_q, 0), 64'h5000);
        check("d_out1", q_at(out_q, 1), 64'h5004);
        stale = 1'b0;
        foreach (out_q[i]) if (out_q[i] < 64'h5000) stale = 1'b1;
        check("d_no_stale", stale, 0);

        // Double redirect while draining.
        do_reset(3);
        step();
        step();
        redirect = 1'b1; redirect_pc = 64'h3000;
        step();
        redirect = 1'b0;
        step();
        redirect = 1'b1; redirect_pc = 64'h4000;
        step();
        redirect = 1'b0;
        repeat (16) step();
        check("e_out0", q_at(out_q, 0), 64'h4000);
        check("e_out1", q_at(out_q, 1), 64'h4004);
        stale = 1'b0;
        foreach (out_q[i]) if (out_q[i] < 64'h4000 || out_q[i] >= 64'h5000) stale = 1'b1;
        check("e_only_4000", stale, 0);

        // Address wrap-around and mid-stream reset on the second instance.
        clear_mon();
        rst_w = 1'b0;
        repeat (6) step();
        check("f_req0", q_at(req_w_q, 0), WRAP_PC);
        check("f_req1", q_at(req_w_q, 1), 64'h0);
        check("f_out0", q_at(out_w_q, 0), WRAP_PC);
        check("f_out1", q_at(out_w_q, 1), 64'h0);
        check("f_out2", q_at(out_w_q, 2), 64'h4);
        out_ready_w = 1'b0;
        repeat (6) step();
        @(negedge clk);
        check("f_full_valid", out_valid_w, 1);
        step();
        rst_w = 1'b1;
        @(negedge clk);
        check("f_rst_out_valid", out_valid_w, 0);
        check("f_rst_req_valid", mem_req_valid_w, 0);
        step();
        rst_w = 1'b0;
        clear_mon();
        @(negedge clk);
        check("f_post_rst_empty", out_valid_w, 0);
        check("f_refetch_addr", mem_req_addr_w, WRAP_PC);
        step();
        out_ready_w = 1'b1;
        repeat (3) step();
        check("f_post_rst_out0", q_at(out_w_q, 0), WRAP_PC);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prefetch_unit
